aibcr3_scan_seq_ctrl: RTL
=========================

AIBCR3_SCAN_SEQ_CTRL -- requirements
Module: aibcr3_scan_seq_ctrl

Interface
REQ-001 Parameters SHALL be listed one per line as name, default, meaning.
REQ-002 Parameter CHAIN_LEN, default 16, gives the number of scan flops in the controlled chain; the legal range is 2..64.
REQ-003 Parameter CNT_W, default 7, gives the shift-counter width, which SHALL be at least clog2(CHAIN_LEN+1).
REQ-004 Ports SHALL be listed one per line as name, direction, width, meaning, with clock and reset first.
REQ-005 CK, input, 1: the single clock, shared with the chain flops; all logic is posedge CK.
REQ-006 RST, input, 1: synchronous, active-high reset.
REQ-007 REQ, input, 1: operation request, sampled only in IDLE.
REQ-008 MODE, input, 1: 0 = load only (shift); 1 = capture, then shift (readback plus load).
REQ-009 WDATA, input, CHAIN_LEN: load pattern; bit k is destined for chain cell k (cell 0 is nearest SI).
REQ-010 ABORT, input, 1: terminates an active operation.
REQ-011 SO, input, 1: scQ of chain cell CHAIN_LEN-1.
REQ-012 SE, output, 1: chain scan enable (1 = shift, 0 = functional capture).
REQ-013 SI, output, 1: serial data into chain cell 0.
REQ-014 CK_EN, output, 1: chain clock-gate enable; the chain advances only on edges where CK_EN=1.
REQ-015 BUSY, output, 1: high in every state other than IDLE.
REQ-016 DONE, output, 1: one-cycle completion pulse.
REQ-017 RDATA, output, CHAIN_LEN: readback; bit k holds the pre-shift content of cell k.
REQ-018 ABORTED, output, 1: one-cycle pulse when an operation is abandoned.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, CAPTURE, SHIFT, FINISH.
REQ-020 In IDLE, when REQ=1 and ABORT=0, the block SHALL latch WDATA into shreg, latch MODE, clear cnt, and go to CAPTURE if MODE=1 or to SHIFT if MODE=0.
REQ-021 In IDLE, REQ=1 together with ABORT=1 SHALL NOT be accepted: the state stays IDLE and ABORTED stays 0.
REQ-022 REQ SHALL be ignored in every state other than IDLE; no request is queued.
REQ-023 CAPTURE SHALL last exactly one cycle with SE=0 and CK_EN=1, so the chain loads its functional D; it then goes to SHIFT.
REQ-024 In SHIFT, the block SHALL drive SE=1, CK_EN=1 and SI=shreg[CHAIN_LEN-1] combinationally from the registered shreg.
REQ-025 At each SHIFT edge, shreg SHALL update to {shreg[CHAIN_LEN-2:0], SO} and cnt SHALL increment.
REQ-026 The SHIFT state SHALL be occupied for exactly CHAIN_LEN cycles; when cnt reaches CHAIN_LEN-1 at an edge, the next state SHALL be FINISH.
REQ-027 After the shift completes, the chain SHALL hold WDATA, with cell k = WDATA[k], and shreg SHALL hold the prior chain content, with bit k = old cell k.
REQ-028 FINISH SHALL last one cycle: DONE=1, RDATA is updated from shreg at the entering edge and is valid while DONE=1, SE=0, CK_EN=0; the next state is IDLE.
REQ-029 RDATA SHALL hold its value until the next FINISH or RST.
REQ-030 In MODE=0, RDATA SHALL carry the content the chain held before the shift.
REQ-031 Latency, with the REQ-accept edge as cycle 0: MODE=0 SHALL give DONE in cycle CHAIN_LEN+1; MODE=1 SHALL give DONE in cycle CHAIN_LEN+2.
REQ-032 Outside CAPTURE and SHIFT, SE SHALL be 0, CK_EN SHALL be 0 and SI SHALL be 0.
REQ-033 ABORT=1 in CAPTURE or SHIFT SHALL cause the next state to be IDLE and ABORTED=1 for one cycle.
REQ-034 An abort SHALL leave RDATA unchanged and SHALL NOT assert DONE.
REQ-035 On the abort cycle, the shift or capture edge itself still occurs, because CK_EN is already 1.
REQ-036 ABORT in FINISH SHALL be ignored: DONE still pulses.
REQ-037 DONE and ABORTED SHALL never both be 1 in the same cycle.
REQ-038 cnt SHALL NOT wrap: it saturates at CHAIN_LEN-1, and SHIFT exits at that point.

Reset
REQ-039 RST=1 at a posedge SHALL force state=IDLE, cnt=0, shreg=0 and RDATA=0, regardless of state, including mid-SHIFT.
REQ-040 From the first edge with RST=1, outputs SHALL be SE=0, SI=0, CK_EN=0, BUSY=0, DONE=0 and ABORTED=0.
REQ-041 RST SHALL take priority over REQ and ABORT.
REQ-042 The chain flops' own asynchronous clear is external to this block; this block does not drive it.

Verification
REQ-043 Load, CHAIN_LEN=16, chain initially 0: MODE=0, WDATA=16'hA5C3, with a behavioural chain model. Required: DONE in cycle 17, chain=16'hA5C3, RDATA=16'h0000, SE high for exactly 16 cycles.
REQ-044 Readback: chain functional D=16'h1234, MODE=1, WDATA=16'hFFFF. Required: one SE=0/CK_EN=1 cycle, then DONE in cycle 18, RDATA=16'h1234, chain=16'hFFFF.
REQ-045 Abort: ABORT in the 5th SHIFT cycle. Required: ABORTED pulse, BUSY=0 next cycle, no DONE, RDATA unchanged, CK_EN=0 afterwards.
REQ-046 Reset mid-op: RST in the 8th SHIFT cycle. Required: IDLE with all outputs 0 on the next cycle; a new REQ then completes normally.
REQ-047 Busy and same-cycle conditions: REQ held high through an operation SHALL give back-to-back operations with exactly one IDLE cycle between DONE and the next accept.
REQ-048 REQ together with ABORT in IDLE SHALL not be accepted.
REQ-049 Boundary: with CHAIN_LEN=2, MODE=0, WDATA=2'b10, DONE SHALL come in cycle 3, with chain cell1=1 and cell0=0.

Source files
------------

// File: rtl/aibcr3_scan_seq_ctrl.sv
`timescale 1ns/1ps
// aibcr3_scan_seq_ctrl
// Sequences one load (MODE=0) or capture-then-load (MODE=1) pass over an
// external scan chain of CHAIN_LEN flops. The new pattern is shifted out of
// shreg MSB-first on SI while SO is shifted in at the LSB. After CHAIN_LEN
// shifts the chain holds WDATA and shreg holds the old chain content, which
// is published on RDATA.
//
// Parameters:
//   CHAIN_LEN  16  number of scan flops in the chain (2..64)
//   CNT_W      7   shift-counter width, >= clog2(CHAIN_LEN+1)
//
// Ports:
//   CK       in   1          clock shared with the chain, posedge
//   RST      in   1          synchronous active-high reset
//   REQ      in   1          operation request, sampled only in idle
//   MODE     in   1          0 = load only, 1 = capture then load
//   WDATA    in   CHAIN_LEN  load pattern, bit k goes to chain cell k
//   ABORT    in   1          abandons a capture/shift in progress
//   SO       in   1          scan output of chain cell CHAIN_LEN-1
//   SE       out  1          chain scan enable (1 = shift, 0 = capture)
//   SI       out  1          serial data into chain cell 0
//   CK_EN    out  1          chain clock-gate enable
//   BUSY     out  1          high whenever not idle
//   DONE     out  1          one-cycle completion pulse
//   RDATA    out  CHAIN_LEN  pre-shift chain content, bit k = old cell k
//   ABORTED  out  1          one-cycle pulse after an abandoned operation
module aibcr3_scan_seq_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 REQ,
  input  logic                 MODE,
  input  logic [CHAIN_LEN-1:0] WDATA,
  input  logic                 ABORT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 CK_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RDATA,
  output logic                 ABORTED
);

  typedef enum logic [1:0] {StIdle, StCapture, StShift, StFinish} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
  logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 aborted_q, aborted_d;
  logic                 cnt_last;

  assign cnt_last = (cnt_q == CntLast);

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    aborted_d = 1'b0;
    SE        = 1'b0;
    SI        = 1'b0;
    CK_EN     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // MODE only steers this branch, so it needs no register of its own.
        if (REQ && !ABORT) begin
          shreg_d = WDATA;
          cnt_d   = '0;
          state_d = MODE ? StCapture : StShift;
        end
      end

      StCapture: begin
        // SE=0 with the clock enabled loads the chain's functional D.
        CK_EN = 1'b1;
        if (ABORT) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else begin
          state_d = StShift;
        end
      end

      StShift: begin
        SE      = 1'b1;
        CK_EN   = 1'b1;
        SI      = shreg_q[CHAIN_LEN-1];
        // The chain shifts on this edge even when aborting, so shreg tracks it.
        shreg_d = {shreg_q[CHAIN_LEN-2:0], SO};
        cnt_d   = cnt_last ? cnt_q : cnt_q + CNT_W'(1);
        if (ABORT) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (cnt_last) begin
          state_d = StFinish;
          // Capture the fully shifted value, including the final SO bit.
          rdata_d = shreg_d;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign BUSY    = (state_q != StIdle);
  assign DONE    = (state_q == StFinish);
  assign RDATA   = rdata_q;
  assign ABORTED = aborted_q;

endmodule
